// File: rtl/rx_buffer.sv
// Receive FIFO that sits behind a UART engine. Each entry holds one data byte
// and its parity and framing error bits. The head entry is visible without a read latency.
module rx_buffer #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          RX_STATUS,
    input  logic [7:0]    UART_DATA,
    input  logic          PERR,
    input  logic          FERR,
    input  logic          READ,
    input  logic          CLR_OVF,
    output logic [7:0]    RD_DATA,
    output logic          HEAD_PE,
    output logic          HEAD_FE,
    output logic          RXRDY,
    output logic          FULL,
    output logic          OVF,
    output logic [CW-1:0] COUNT
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rx_status_q;
    logic          armed;
    logic          ovf;

    logic          push;
    logic          pop;
    logic          is_full;
    logic          push_ok;
    logic          drop;
    logic [9:0]    head;

    // Handshake: READ is a pop request that takes effect only while RXRDY is high.
    // A push has no back-pressure. When the buffer is full, the push is dropped
    // unless a pop frees a slot in the same cycle.
    // The push needs "armed" because a level that is already high when reset
    // deasserts must first go low. Only a later rise counts as a new frame.
    assign push    = RX_STATUS && !rx_status_q && armed;
    assign pop     = READ && (count != '0);
    assign is_full = (count == FULL_COUNT);
    assign push_ok = push && (!is_full || pop);
    assign drop    = push && is_full && !pop;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_status_q <= 1'b0;
            armed       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
        end else begin
            rx_status_q <= RX_STATUS;
            if (!RX_STATUS)
                armed <= 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                ovf <= 1'b1;
            else if (CLR_OVF)
                ovf <= 1'b0;
        end
    end

    // Storage is not reset. The count gate below hides stale contents.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= {FERR, PERR, UART_DATA};
    end

    assign head    = mem[rd_ptr];
    assign RXRDY   = (count != '0);
    assign FULL    = is_full;
    assign OVF     = ovf;
    assign COUNT   = count;
    assign RD_DATA = RXRDY ? head[7:0] : 8'h00;
    assign HEAD_PE = RXRDY ? head[8]   : 1'b0;
    assign HEAD_FE = RXRDY ? head[9]   : 1'b0;

endmodule
